// File: rtl/biquad_capture_pkg.sv
// Shared types and helpers for the biquad capture sequencer.
package biquad_capture_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDelay  = 3'd1,
    StGate   = 3'd2,
    StSettle = 3'd3,
    StFrst   = 3'd4
  } capture_state_t;

  // Timed phases run in encoding order, StDelay first through StFrst last.
  localparam int unsigned NumPhases = 4;
  localparam capture_state_t PhaseFirst = StDelay;
  localparam capture_state_t PhaseLast  = StFrst;

  function automatic int unsigned chan_slice(int unsigned c, int unsigned chan_w);
    return c * chan_w;
  endfunction

  // First phase after 'from' whose length is nonzero; StIdle when none remain.
  function automatic capture_state_t next_phase(capture_state_t from,
                                                logic [NumPhases-1:0] nz);
    capture_state_t nxt;
    nxt = StIdle;
    for (int i = NumPhases - 1; i >= 0; i--) begin
      if (nz[i] && (i + int'(PhaseFirst)) > int'(from)) nxt = capture_state_t'(3'(i + 1));
    end
    return nxt;
  endfunction

endpackage

// File: rtl/biquad_capture_gate_if.sv
// Control, config and data bundle between the capture sequencer and its driver.
interface biquad_capture_gate_if #(
  parameter int unsigned NCHAN = 2,
  parameter int unsigned NSAMP = 8,
  parameter int unsigned SAMPW = 16,
  parameter int unsigned CNTW  = 16
);
  localparam int unsigned DatW = NCHAN * NSAMP * SAMPW;

  logic             capture_i;
  logic             abort_i;
  logic [CNTW-1:0]  cfg_delay_i;
  logic [CNTW-1:0]  cfg_gate_i;
  logic [CNTW-1:0]  cfg_settle_i;
  logic [CNTW-1:0]  cfg_rst_i;
  logic [NCHAN-1:0] cfg_chmask_i;
  logic [DatW-1:0]  dat_i;
  logic [DatW-1:0]  dat_o;
  logic             gate_o;
  logic             filt_rst_o;
  logic             busy_o;
  logic             done_o;
  logic             missed_o;

  modport slave (
    input  capture_i, abort_i, cfg_delay_i, cfg_gate_i, cfg_settle_i, cfg_rst_i,
           cfg_chmask_i, dat_i,
    output dat_o, gate_o, filt_rst_o, busy_o, done_o, missed_o
  );

  modport master (
    output capture_i, abort_i, cfg_delay_i, cfg_gate_i, cfg_settle_i, cfg_rst_i,
           cfg_chmask_i, dat_i,
    input  dat_o, gate_o, filt_rst_o, busy_o, done_o, missed_o
  );
endinterface

// File: rtl/biquad_gate_chan.sv
// One channel of registered gating: passes the input when enabled, else zero.
module biquad_gate_chan #(
  parameter int unsigned W = 128
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         en_i,
  input  logic [W-1:0] dat_i,
  output logic [W-1:0] dat_o
);
  logic [W-1:0] dat_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) dat_q <= '0;
    else          dat_q <= en_i ? dat_i : '0;
  end

  assign dat_o = dat_q;
endmodule

// File: rtl/biquad_capture_gate.sv
// Capture sequencer: trigger -> delay -> gated data window -> settle -> filter reset pulse.
module biquad_capture_gate
  import biquad_capture_pkg::*;
#(
  parameter int unsigned NCHAN = 2,
  parameter int unsigned NSAMP = 8,
  parameter int unsigned SAMPW = 16,
  parameter int unsigned CNTW  = 16
) (
  input logic                 aclk,
  input logic                 aresetn,
  biquad_capture_gate_if.slave bus
);
  localparam int unsigned ChanW = NSAMP * SAMPW;

  capture_state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NumPhases-1:0][CNTW-1:0] len_q, len_d, cfg_in, lens_src;
  logic [NumPhases-1:0] nz_in, nz_q;
  logic [NCHAN-1:0] mask_q, mask_d, chan_en;
  logic [1:0] phase_idx;
  logic cap_q, trig, enter;
  logic gate_q, gate_d, frst_q, frst_d, done_q, done_d, missed_q, missed_d;

  assign trig   = bus.capture_i & ~cap_q;
  assign cfg_in = {bus.cfg_rst_i, bus.cfg_settle_i, bus.cfg_gate_i, bus.cfg_delay_i};

  always_comb begin
    nz_in = '0;
    nz_q  = '0;
    for (int i = 0; i < int'(NumPhases); i++) begin
      nz_in[i] = |cfg_in[i];
      nz_q[i]  = |len_q[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cap_q    <= 1'b0;
      len_q    <= '0;
      mask_q   <= '0;
      gate_q   <= 1'b0;
      frst_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_q    <= bus.capture_i;
      len_q    <= len_d;
      mask_q   <= mask_d;
      gate_q   <= gate_d;
      frst_q   <= frst_d;
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    mask_d    = mask_q;
    lens_src  = len_q;
    enter     = 1'b0;
    done_d    = 1'b0;
    missed_d  = 1'b0;
    phase_idx = '0;
    if (state_q == StIdle) begin
      if (trig) begin
        len_d    = cfg_in;
        mask_d   = bus.cfg_chmask_i;
        lens_src = cfg_in;
        state_d  = next_phase(StIdle, nz_in);
        enter    = 1'b1;
      end
    end else begin
      missed_d = trig;
      // Abort jumps as if SETTLE just ended, so only FRST (if nonzero) remains.
      if (bus.abort_i && state_q != PhaseLast) begin
        state_d = next_phase(StSettle, nz_q);
        enter   = 1'b1;
      end else if (cnt_q == '0) begin
        state_d = next_phase(state_q, nz_q);
        enter   = 1'b1;
      end else begin
        cnt_d = cnt_q - CNTW'(1);
      end
    end
    if (enter) begin
      done_d = (state_d == StIdle);
      if (state_d == StIdle) begin
        cnt_d = '0;
      end else begin
        phase_idx = 2'(int'(state_d) - 1);
        cnt_d     = lens_src[phase_idx] - CNTW'(1);
      end
    end
  end

  always_comb begin
    gate_d  = (state_q == StGate);
    frst_d  = (state_q == StFrst);
    chan_en = {NCHAN{gate_d}} & mask_q;
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    localparam int unsigned Off = chan_slice(c, ChanW);
    biquad_gate_chan #(
      .W(ChanW)
    ) u_chan (
      .aclk   (aclk),
      .aresetn(aresetn),
      .en_i   (chan_en[c]),
      .dat_i  (bus.dat_i[Off +: ChanW]),
      .dat_o  (bus.dat_o[Off +: ChanW])
    );
  end

  assign bus.gate_o     = gate_q;
  assign bus.filt_rst_o = frst_q;
  assign bus.busy_o     = (state_q != StIdle);
  assign bus.done_o     = done_q;
  assign bus.missed_o   = missed_q;
endmodule

// File: tb/tb_biquad_capture_gate.sv
// Directed bench for biquad_capture_gate; cycle 0 is the cycle capture_i first reads high.
module tb_biquad_capture_gate;
  localparam int unsigned NCHAN = 2;
  localparam int unsigned NSAMP = 8;
  localparam int unsigned SAMPW = 16;
  localparam int unsigned CNTW  = 16;
  localparam int unsigned ChanW = NSAMP * SAMPW;
  localparam int unsigned DatW  = NCHAN * ChanW;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  biquad_capture_gate_if #(
    .NCHAN(NCHAN), .NSAMP(NSAMP), .SAMPW(SAMPW), .CNTW(CNTW)
  ) bus ();

  biquad_capture_gate #(
    .NCHAN(NCHAN), .NSAMP(NSAMP), .SAMPW(SAMPW), .CNTW(CNTW)
  ) dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DatW-1:0] got,
                          input logic [DatW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [DatW-1:0] ramp(input int k);
    logic [DatW-1:0] v;
    logic [7:0] kb;
    v  = '0;
    kb = 8'(k);
    for (int c = 0; c < int'(NCHAN); c++)
      for (int s = 0; s < int'(NSAMP); s++)
        v[c*ChanW + s*SAMPW +: SAMPW] = {kb, 4'(c), 4'(s)};
    return v;
  endfunction

  function automatic logic [DatW-1:0] mask_dat(input logic [DatW-1:0] v,
                                               input logic [NCHAN-1:0] m);
    logic [DatW-1:0] r;
    r = v;
    for (int c = 0; c < int'(NCHAN); c++)
      if (!m[c]) r[c*ChanW +: ChanW] = '0;
    return r;
  endfunction

  function automatic logic [4:0] flags();
    return {bus.missed_o, bus.done_o, bus.busy_o, bus.filt_rst_o, bus.gate_o};
  endfunction

  task automatic set_cfg(input int d, input int g, input int s, input int r,
                         input logic [NCHAN-1:0] m);
    bus.cfg_delay_i  = CNTW'(d);
    bus.cfg_gate_i   = CNTW'(g);
    bus.cfg_settle_i = CNTW'(s);
    bus.cfg_rst_i    = CNTW'(r);
    bus.cfg_chmask_i = m;
  endtask

  // Expected windows are inclusive cycle ranges; -1 disables a single-cycle event.
  task automatic run_seq(input string name, input int n, input int hold, input int recap,
                         input int abort_at, input int g0, input int g1, input int f0,
                         input int f1, input int done_at, input int busy_hi,
                         input int missed_at, input logic [NCHAN-1:0] m);
    logic [CNTW-1:0] sd, sg, ss, sr;
    logic [NCHAN-1:0] sm;
    logic [4:0] ef;
    logic [DatW-1:0] ed;
    int j;
    sd = bus.cfg_delay_i; sg = bus.cfg_gate_i; ss = bus.cfg_settle_i;
    sr = bus.cfg_rst_i;   sm = bus.cfg_chmask_i;
    for (int k = 0; k < n; k++) begin
      bus.capture_i = (k < hold) || (k == recap);
      bus.abort_i   = (k == abort_at);
      bus.dat_i     = ramp(k);
      // Config moves after the trigger must not affect the running sequence.
      if (k == 1) set_cfg(7, 7, 7, 7, ~m);
      step();
      j  = k + 1;
      ef = {j == missed_at, j == done_at, j >= 1 && j <= busy_hi, j >= f0 && j <= f1,
            j >= g0 && j <= g1};
      ed = (j >= g0 && j <= g1) ? mask_dat(ramp(k), m) : '0;
      check_eq($sformatf("%s.c%0d.flags", name, j), DatW'(flags()), DatW'(ef));
      check_eq($sformatf("%s.c%0d.dat", name, j), bus.dat_o, ed);
    end
    set_cfg(int'(sd), int'(sg), int'(ss), int'(sr), sm);
    bus.capture_i = 1'b0;
    bus.abort_i   = 1'b0;
    step();
    step();
  endtask

  initial begin
    int seen;
    aresetn = 1'b0;
    bus.capture_i = 1'b0;
    bus.abort_i   = 1'b0;
    bus.dat_i     = ramp(99);
    set_cfg(3, 4, 2, 5, 2'b11);
    step(); step(); step();
    check_eq("reset.flags", DatW'(flags()), '0);
    check_eq("reset.dat", bus.dat_o, '0);
    aresetn = 1'b1;
    step();

    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    check_eq("abort_idle.flags", DatW'(flags()), '0);
    step();

    run_seq("basic", 20, 1, -1, -1, 5, 8, 11, 15, 15, 14, -1, 2'b11);
    run_seq("trig_abort_same", 20, 1, -1, 0, 5, 8, 11, 15, 15, 14, -1, 2'b11);

    set_cfg(1, 8, 1, 1, 2'b10);
    run_seq("mask10", 16, 1, -1, -1, 3, 10, 12, 12, 12, 11, -1, 2'b10);

    set_cfg(0, 1, 0, 0, 2'b11);
    run_seq("gate_only", 5, 1, -1, -1, 2, 2, 1, 0, 2, 1, -1, 2'b11);

    set_cfg(0, 0, 0, 0, 2'b11);
    run_seq("all_zero", 4, 1, -1, -1, 1, 0, 1, 0, 1, 0, -1, 2'b11);

    set_cfg(3, 4, 2, 5, 2'b11);
    run_seq("hold100", 105, 100, -1, -1, 5, 8, 11, 15, 15, 14, -1, 2'b11);
    run_seq("retrig_gate", 20, 1, 6, -1, 5, 8, 11, 15, 15, 14, 7, 2'b11);

    set_cfg(3, 4, 2, 3, 2'b11);
    run_seq("abort", 14, 1, -1, 5, 5, 6, 7, 9, 9, 8, -1, 2'b11);

    // Reset in the first SETTLE cycle (cycle 8) must abandon the sequence silently.
    set_cfg(3, 4, 2, 5, 2'b11);
    bus.capture_i = 1'b1;
    step();
    bus.capture_i = 1'b0;
    for (int k = 1; k < 8; k++) step();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    check_eq("rst_mid.flags", DatW'(flags()), '0);
    check_eq("rst_mid.dat", bus.dat_o, '0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.filt_rst_o || bus.done_o || bus.busy_o) seen++;
    end
    check_eq("rst_mid.quiet", DatW'(seen), '0);
    run_seq("after_rst", 20, 1, -1, -1, 5, 8, 11, 15, 15, 14, -1, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
